hvac_scheduler: RTL and testbench

- Sequential controller that owns the single shared climate actuator path and decides, per clock, whether cooling, heating or neither is driven.
- Consumes the same sensor set as the room climate logic: temperature, presence, window state, plus a user enable.
- Adds hysteresis, minimum-run time and restart lockout so AC and heater never run together or short-cycle.
- Sits between the sensor interface and the actuator drivers; `ac_cool` and `heat_on` feed the power stage directly.

---
 rtl/hvac_scheduler.sv | 157 +++++++++++++++
 tb/tb_hvac_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hvac_scheduler.sv
// hvac_scheduler: arbitrates the shared climate actuator path between cooling
// and heating. Hysteresis thresholds, a minimum-run time and a post-shutdown
// lockout keep the two actuators mutually exclusive and stop short-cycling.
// State is visible on `state` (IDLE=0, COOL=1, HEAT=2, LOCKOUT=3).
// `tick` is a one-cycle timebase strobe; there is no valid/ready handshake.
// Optional macro PRESENCE_HOLD_EN: presence is stretched by HOLD_TICKS ticks
// after the occupant leaves; without it raw `presence` is used directly.
module hvac_scheduler #(
  parameter int TEMP_W        = 8,
  parameter int COOL_ON       = 26,
  parameter int COOL_OFF      = 24,
  parameter int HEAT_ON       = 18,
  parameter int HEAT_OFF      = 20,
  parameter int MIN_RUN_TICKS = 8,
  parameter int LOCKOUT_TICKS = 4,
  parameter int HOLD_TICKS    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              enable,
  input  logic [TEMP_W-1:0] temp,
  input  logic              presence,
  input  logic              window,
  output logic              ac_cool,
  output logic              heat_on,
  output logic              lockout,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COOL    = 2'd1,
    ST_HEAT    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_e;

  localparam logic [TEMP_W-1:0] COOL_ON_T  = TEMP_W'(COOL_ON);
  localparam logic [TEMP_W-1:0] COOL_OFF_T = TEMP_W'(COOL_OFF);
  localparam logic [TEMP_W-1:0] HEAT_ON_T  = TEMP_W'(HEAT_ON);
  localparam logic [TEMP_W-1:0] HEAT_OFF_T = TEMP_W'(HEAT_OFF);
  localparam logic [7:0]        MIN_RUN_C  = 8'(MIN_RUN_TICKS);
  localparam logic [7:0]        LOCK_C     = 8'(LOCKOUT_TICKS);

  // Reject threshold orderings that would let both modes be requested at once.
  if (!(HEAT_ON < HEAT_OFF && HEAT_OFF < COOL_OFF && COOL_OFF < COOL_ON &&
        MIN_RUN_TICKS >= 1 && MIN_RUN_TICKS <= 255 &&
        LOCKOUT_TICKS >= 1 && LOCKOUT_TICKS <= 255 &&
        HOLD_TICKS >= 1 && HOLD_TICKS <= 255)) begin : g_param_check
    $error("hvac_scheduler: illegal parameter set");
  end

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ac_cool_q, heat_on_q, lockout_q;
  logic       presence_eff;
  logic       ok;

`ifdef PRESENCE_HOLD_EN
  localparam logic [7:0] HOLD_C = 8'(HOLD_TICKS);
  logic [7:0] hold_q, hold_d;

  // Hold counter: reload while occupied, count down on ticks once vacated.
  always_comb begin
    hold_d = hold_q;
    if (presence) begin
      hold_d = HOLD_C;
    end else if (tick && hold_q != 8'd0) begin
      hold_d = hold_q - 8'd1;
    end
  end

  // Hold counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= 8'd0;
    end else begin
      hold_q <= hold_d;
    end
  end

  assign presence_eff = presence | (hold_q != 8'd0);
`else
  assign presence_eff = presence;
`endif

  assign ok = enable & presence_eff & ~window;

  // Next-state logic: window is a safety exit, otherwise exits wait for MIN_RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ok && temp >= COOL_ON_T) begin
          state_d = ST_COOL;
        end else if (ok && temp <= HEAT_ON_T) begin
          state_d = ST_HEAT;
        end
      end
      ST_COOL: begin
        if (window) begin
          state_d = ST_LOCKOUT;
        end else if (cnt_q >= MIN_RUN_C &&
                     (temp <= COOL_OFF_T || !enable || !presence_eff)) begin
          state_d = ST_LOCKOUT;
        end
      end
      ST_HEAT: begin
        if (window) begin
          state_d = ST_LOCKOUT;
        end else if (cnt_q >= MIN_RUN_C &&
                     (temp >= HEAT_OFF_T || !enable || !presence_eff)) begin
          state_d = ST_LOCKOUT;
        end
      end
      ST_LOCKOUT: begin
        if (cnt_q >= LOCK_C) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Tick counter: restarts on every state change, saturates at 255.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = 8'd0;
    end else if (tick && cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // State, counter and registered output decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      ac_cool_q <= 1'b0;
      heat_on_q <= 1'b0;
      lockout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ac_cool_q <= (state_d == ST_COOL);
      heat_on_q <= (state_d == ST_HEAT);
      lockout_q <= (state_d == ST_LOCKOUT);
    end
  end

  assign ac_cool = ac_cool_q;
  assign heat_on = heat_on_q;
  assign lockout = lockout_q;
  assign state   = state_q;

endmodule

// File: tb/tb_hvac_scheduler.sv
// Testbench for hvac_scheduler: directed scenarios plus randomized traffic,
// every cycle compared against a rule-level reference model.
module tb_hvac_scheduler;

  localparam int M_IDLE = 0;
  localparam int M_COOL = 1;
  localparam int M_HEAT = 2;
  localparam int M_LOCK = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       enable;
  logic [7:0] temp;
  logic       presence;
  logic       window;
  logic       ac_cool;
  logic       heat_on;
  logic       lockout;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected {state, ac_cool, heat_on, lockout} per edge.
  logic [4:0] exp_q[$];

  // Reference model: current mode, ticks spent in that mode, presence hold left.
  int m_mode;
  int m_ticks;
  int m_hold;

  hvac_scheduler dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .enable   (enable),
    .temp     (temp),
    .presence (presence),
    .window   (window),
    .ac_cool  (ac_cool),
    .heat_on  (heat_on),
    .lockout  (lockout),
    .state    (state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_ticks = 0;
    m_hold  = 0;
  endtask

  // Apply the controller rules to the inputs present this cycle.
  task automatic model_advance();
    bit occupied;
    bit ok;
    int nxt;
`ifdef PRESENCE_HOLD_EN
    occupied = presence || (m_hold > 0);
`else
    occupied = presence;
`endif
    ok  = enable && occupied && !window;
    nxt = m_mode;
    if (m_mode == M_IDLE) begin
      if (ok && temp >= 26) nxt = M_COOL;
      else if (ok && temp <= 18) nxt = M_HEAT;
    end else if (m_mode == M_COOL) begin
      if (window) nxt = M_LOCK;
      else if (m_ticks >= 8 && (temp <= 24 || !enable || !occupied)) nxt = M_LOCK;
    end else if (m_mode == M_HEAT) begin
      if (window) nxt = M_LOCK;
      else if (m_ticks >= 8 && (temp >= 20 || !enable || !occupied)) nxt = M_LOCK;
    end else begin
      if (m_ticks >= 4) nxt = M_IDLE;
    end
    if (nxt != m_mode) m_ticks = 0;
    else if (tick) m_ticks = (m_ticks >= 255) ? 255 : m_ticks + 1;
    if (presence) m_hold = 16;
    else if (tick && m_hold > 0) m_hold = m_hold - 1;
    m_mode = nxt;
    exp_q.push_back({2'(nxt), nxt == M_COOL, nxt == M_HEAT, nxt == M_LOCK});
  endtask

  // Driver: inputs change on the falling edge, outputs are sampled after rising.
  task automatic step(input logic en, input logic pr, input logic wi,
                      input logic [7:0] t, input logic tk);
    @(negedge clk);
    enable   = en;
    presence = pr;
    window   = wi;
    temp     = t;
    tick     = tk;
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    tick     = 1'b0;
    enable   = 1'b0;
    presence = 1'b0;
    window   = 1'b0;
    temp     = 8'd22;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({state, ac_cool, heat_on, lockout} !== 5'b0) begin
      errors++;
      $display("FAIL reset_values: got %b expected %b", {state, ac_cool, heat_on, lockout}, 5'b0);
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_cool_cycle();
    logic [4:0] got, want;
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b1, 1'b0, (i == 0) ? 8'd26 : (i <= 8) ? 8'd25 : 8'd24, 1'b1);
      got = {state, ac_cool, heat_on, lockout};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL cool_cycle step %0d: got %b expected %b", i, got, want);
      end
      if (i == 0 || i == 8 || i == 9 || i == 13 || i == 14) begin
        want = (i == 0 || i == 8) ? 5'b01100 : (i == 14) ? 5'b00000 : 5'b11001;
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL cool_cycle_fixed step %0d: got %b expected %b", i, got, want);
        end
      end
    end
  endtask

  task automatic test_min_run();
    logic [4:0] got, want;
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b1, 1'b0, (i <= 3) ? 8'd26 : (i <= 9) ? 8'd20 : 8'd22, 1'b1);
      got = {state, ac_cool, heat_on, lockout};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL min_run step %0d: got %b expected %b", i, got, want);
      end
      if (i == 8 || i == 9) begin
        checks++;
        if (lockout !== (i == 9) || ac_cool !== (i == 8)) begin
          errors++;
          $display("FAIL min_run_edge step %0d: got ac=%b lock=%b expected ac=%b lock=%b",
                   i, ac_cool, lockout, i == 8, i == 9);
        end
      end
    end
  endtask

  task automatic test_window_safety();
    logic [4:0] got, want;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, (i >= 3 && i < 15), (i == 15) ? 8'd19 : 8'd18, 1'b1);
      got = {state, ac_cool, heat_on, lockout};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL window_safety step %0d: got %b expected %b", i, got, want);
      end
      if (i == 3 || i == 14) begin
        want = (i == 3) ? 5'b11001 : 5'b00000;
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL window_safety_fixed step %0d: got %b expected %b", i, got, want);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] got, want;
    for (int i = 0; i < 35; i++) begin
      step(1'b1, 1'b1, 1'b0, (i == 0) ? 8'd18 : (i <= 8) ? 8'd19 : (i <= 23) ? 8'd30 : 8'd22, 1'b1);
      got = {state, ac_cool, heat_on, lockout};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL back_to_back step %0d: got %b expected %b", i, got, want);
      end
      checks++;
      if (ac_cool && heat_on) begin
        errors++;
        $display("FAIL back_to_back_exclusive step %0d: got ac=1 heat=1 expected not both", i);
      end
      if (i == 9 || i == 14 || i == 15) begin
        want = (i == 9) ? 5'b11001 : (i == 14) ? 5'b00000 : 5'b01100;
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL back_to_back_fixed step %0d: got %b expected %b", i, got, want);
        end
      end
    end
  endtask

  task automatic test_presence_drop();
    logic [4:0] got, want;
    for (int i = 0; i < 32; i++) begin
      step(1'b1, (i <= 8 || i >= 26), 1'b0, (i == 0) ? 8'd26 : (i <= 25) ? 8'd25 : 8'd22, 1'b1);
      got = {state, ac_cool, heat_on, lockout};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL presence_drop step %0d: got %b expected %b", i, got, want);
      end
`ifdef PRESENCE_HOLD_EN
      if (i == 24 || i == 25) begin
        want = (i == 24) ? 5'b01100 : 5'b11001;
`else
      if (i == 9) begin
        want = 5'b11001;
`endif
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL presence_drop_fixed step %0d: got %b expected %b", i, got, want);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] got, want;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'd26, 1'b1);
      got = {state, ac_cool, heat_on, lockout};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL async_reset_pre step %0d: got %b expected %b", i, got, want);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({state, ac_cool, heat_on, lockout} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset_immediate: got %b expected %b", {state, ac_cool, heat_on, lockout}, 5'b0);
    end
    model_reset();
    #1 rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 8'd26, 1'b0);
    got = {state, ac_cool, heat_on, lockout};
    want = exp_q.pop_front();
    checks++;
    if (got !== want || got !== 5'b01100) begin
      errors++;
      $display("FAIL async_reset_restart: got %b expected %b", got, 5'b01100);
    end
  endtask

  task automatic test_random();
    logic [4:0] got, want;
    logic [7:0] t;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 19))
        0:       t = 8'd0;
        1:       t = 8'd255;
        default: t = 8'($urandom_range(14, 30));
      endcase
      step($urandom_range(0, 15) != 0, $urandom_range(0, 7) != 0,
           $urandom_range(0, 31) == 0, t, $urandom_range(0, 2) == 0);
      got = {state, ac_cool, heat_on, lockout};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random cycle %0d: got %b expected %b", i, got, want);
      end
      checks++;
      if (ac_cool && heat_on) begin
        errors++;
        $display("FAIL random_exclusive cycle %0d: got ac=1 heat=1 expected not both", i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cool_cycle();
    test_min_run();
    test_window_safety();
    test_back_to_back();
    test_presence_drop();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
